mfcc_feature_packer: RTL and testbench

Parametrised output stage for the MFCC pipeline. It accepts serial DCT coefficients from one or more interleaved audio channels, then requantises each with rounding and saturation to ACTIV_BITS. It assembles the results into per-channel MFCC_FEATURES-wide frame vectors and buffers completed frames in a FIFO with a valid/ready handshake toward the KWS network. It supersedes the single-register, single-channel, no-backpressure output stage of the current accelerator top.

---
 rtl/mfcc_pkg.sv | 23 ++
 rtl/mfcc_frame_fifo.sv | 53 +++++
 rtl/mfcc_feature_packer.sv | 148 ++++++++++++++
 tb/tb_mfcc_feature_packer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
// Shared MFCC definitions: default feature geometry, channel-tag width helper
// and the signed saturation limits used by the requantisers.
package mfcc_pkg;

    localparam int MFCC_FEATURES_DEF = 40;
    localparam int ACTIV_BITS_DEF    = 8;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int sat_hi(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int bits);
        return -(1 << (bits - 1));
    endfunction

    localparam int SAT_HI_DEF = sat_hi(ACTIV_BITS_DEF);
    localparam int SAT_LO_DEF = sat_lo(ACTIV_BITS_DEF);

endpackage

// File: rtl/mfcc_frame_fifo.sv
// Generic synchronous FIFO with occupancy count; push is ignored when full,
// pop is ignored when empty. Shared by several MFCC stages.
module mfcc_frame_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && (count != '0);
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mfcc_feature_packer.sv
// MFCC output stage: requantise serial DCT coefficients, pack per-channel frame
// vectors, queue finished frames. MFCC_SAT_STATUS_EN adds the sat_count port.
module mfcc_feature_packer
    import mfcc_pkg::*;
#(
    parameter int MFCC_FEATURES = MFCC_FEATURES_DEF,
    parameter int ACTIV_BITS    = ACTIV_BITS_DEF,
    parameter int COEF_W        = 32,
    parameter int NUM_CH        = 1,
    parameter int FIFO_DEPTH    = 2,
    parameter int CH_W          = ch_w(NUM_CH)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic signed [COEF_W-1:0]            coef_in,
    input  logic [CH_W-1:0]                     coef_ch,
    input  logic                                coef_valid,
    output logic                                coef_ready,
    input  logic [7:0]                          num_coeffs,
    input  logic [4:0]                          quant_shift,
    input  logic                                flush,
`ifdef MFCC_SAT_STATUS_EN
    output logic [15:0]                         sat_count,
`endif
    output logic [MFCC_FEATURES*ACTIV_BITS-1:0] feat_data,
    output logic [CH_W-1:0]                     feat_ch,
    output logic                                feat_valid,
    input  logic                                feat_ready
);
    localparam int FW = MFCC_FEATURES * ACTIV_BITS;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [COEF_W:0] Q_HI = (COEF_W+1)'(sat_hi(ACTIV_BITS));
    localparam logic signed [COEF_W:0] Q_LO = (COEF_W+1)'(sat_lo(ACTIV_BITS));

    // Round-half-up then arithmetic shift; one extra bit absorbs the rounding carry.
    function automatic logic signed [COEF_W:0] rescale(input logic signed [COEF_W-1:0] c,
                                                        input logic [4:0] sh);
        logic signed [COEF_W:0] sum;
        sum = {c[COEF_W-1], c};
        if (sh != 5'd0) sum = sum + ((COEF_W+1)'(1) << (sh - 5'd1));
        return sum >>> sh;
    endfunction

    logic [NUM_CH-1:0][7:0]   idx;
    logic [NUM_CH-1:0][FW-1:0] asm_vec;
    logic signed [COEF_W:0]   scaled;
    logic [ACTIV_BITS-1:0]    q;
    logic [7:0]               eff_n;
    logic [7:0]               cur_idx;
    logic [FW-1:0]            cur_vec;
    logic [FW-1:0]            push_vec;
    logic                     ch_ok;
    logic                     accept;
    logic                     last;
    logic                     push;
    logic                     pop;
    logic [CW-1:0]            fifo_count;

    assign accept     = coef_valid && coef_ready;
    assign coef_ready = rst_n && !flush && (fifo_count < CW'(FIFO_DEPTH));
    assign ch_ok      = {1'b0, coef_ch} < (CH_W+1)'(NUM_CH);
    assign eff_n      = (num_coeffs == 8'd0 || num_coeffs > 8'(MFCC_FEATURES))
                      ? 8'(MFCC_FEATURES) : num_coeffs;

    always_comb begin
        scaled = rescale(coef_in, quant_shift);
        if (scaled > Q_HI)      q = Q_HI[ACTIV_BITS-1:0];
        else if (scaled < Q_LO) q = Q_LO[ACTIV_BITS-1:0];
        else                    q = scaled[ACTIV_BITS-1:0];
    end

    always_comb begin
        cur_idx = '0;
        cur_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == coef_ch) begin
                cur_idx = idx[c];
                cur_vec = asm_vec[c];
            end
        end
    end

    // A shrunken N mid-frame also completes the frame on this coefficient.
    assign last = cur_idx >= (eff_n - 8'd1);
    assign push = accept && ch_ok && last;

    always_comb begin
        push_vec = cur_vec;
        for (int k = 0; k < MFCC_FEATURES; k++) begin
            if (8'(k) == cur_idx) push_vec[k*ACTIV_BITS +: ACTIV_BITS] = q;
            if (8'(k) >= eff_n)   push_vec[k*ACTIV_BITS +: ACTIV_BITS] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            asm_vec <= '0;
        end else if (flush) begin
            idx     <= '0;
            asm_vec <= '0;
        end else if (accept && ch_ok) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (CH_W'(c) == coef_ch) begin
                    if (last) begin
                        idx[c]     <= '0;
                        asm_vec[c] <= '0;
                    end else begin
                        idx[c] <= idx[c] + 8'd1;
                        for (int k = 0; k < MFCC_FEATURES; k++)
                            if (8'(k) == cur_idx)
                                asm_vec[c][k*ACTIV_BITS +: ACTIV_BITS] <= q;
                    end
                end
            end
        end
    end

`ifdef MFCC_SAT_STATUS_EN
    logic clipped;
    assign clipped = (scaled > Q_HI) || (scaled < Q_LO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        sat_count <= '0;
        else if (flush)                                    sat_count <= '0;
        else if (accept && clipped && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
    end
`endif

    assign feat_valid = (fifo_count != '0);
    assign pop        = feat_valid && feat_ready;

    mfcc_frame_fifo #(
        .WIDTH (FW + CH_W),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush),
        .push     (push),
        .data_in  ({coef_ch, push_vec}),
        .pop      (pop),
        .data_out ({feat_ch, feat_data}),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_mfcc_feature_packer.sv
// Randomised and directed bench for mfcc_feature_packer (2 channels, 2-deep FIFO)
// against an integer-arithmetic frame/queue model.
module tb_mfcc_feature_packer;
    localparam int F   = 40;
    localparam int A   = 8;
    localparam int NCH = 2;
    localparam int DEP = 2;
    localparam int FW  = F * A;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic signed [31:0] coef_in = '0;
    logic [0:0]         coef_ch = '0;
    logic               coef_valid = 1'b0;
    logic               coef_ready;
    logic [7:0]         num_coeffs = '0;
    logic [4:0]         quant_shift = '0;
    logic               flush = 1'b0;
    logic [FW-1:0]      feat_data;
    logic [0:0]         feat_ch;
    logic               feat_valid;
    logic               feat_ready = 1'b0;
`ifdef MFCC_SAT_STATUS_EN
    logic [15:0]        sat_count;
`endif

    mfcc_feature_packer #(
        .MFCC_FEATURES (F),
        .ACTIV_BITS    (A),
        .COEF_W        (32),
        .NUM_CH        (NCH),
        .FIFO_DEPTH    (DEP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coef_in     (coef_in),
        .coef_ch     (coef_ch),
        .coef_valid  (coef_valid),
        .coef_ready  (coef_ready),
        .num_coeffs  (num_coeffs),
        .quant_shift (quant_shift),
        .flush       (flush),
`ifdef MFCC_SAT_STATUS_EN
        .sat_count   (sat_count),
`endif
        .feat_data   (feat_data),
        .feat_ch     (feat_ch),
        .feat_valid  (feat_valid),
        .feat_ready  (feat_ready)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: slot lists per channel plus a queue of finished frames.
    int            slot [NCH][F];
    int            pos  [NCH];
    logic [FW-1:0] qd [$];
    logic [0:0]    qc [$];
    int            satm;

    function automatic int quant(input longint c, input int sh, output bit clip);
        longint v;
        v = c;
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        clip = 1'b0;
        if (v > 127)       begin v = 127;  clip = 1'b1; end
        else if (v < -128) begin v = -128; clip = 1'b1; end
        return int'(v);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            pos[c] = 0;
            for (int k = 0; k < F; k++) slot[c][k] = 0;
        end
        qd.delete();
        qc.delete();
        satm = 0;
    endtask

    task automatic model_accept(input int c, input int ch, input int n, input int sh);
        int ne, qv;
        bit clip;
        logic [FW-1:0] vec;
        ne = (n == 0 || n > F) ? F : n;
        qv = quant(c, sh, clip);
        if (clip && satm < 65535) satm++;
        if (ch < NCH) begin
            slot[ch][pos[ch]] = qv;
            if (pos[ch] >= ne - 1) begin
                vec = '0;
                for (int k = 0; k < ne; k++) vec[k*A +: A] = 8'(slot[ch][k]);
                qd.push_back(vec);
                qc.push_back(1'(ch));
                for (int k = 0; k < F; k++) slot[ch][k] = 0;
                pos[ch] = 0;
            end else begin
                pos[ch]++;
            end
        end
    endtask

    // One clock: drive at negedge, compare settled outputs, then advance the model.
    task automatic cyc(input bit v, input int c, input int ch, input int n, input int sh,
                       input bit fl, input bit fr);
        bit rdy, mv;
        @(negedge clk);
        coef_valid  = v;
        coef_in     = c;
        coef_ch     = 1'(ch);
        num_coeffs  = 8'(n);
        quant_shift = 5'(sh);
        flush       = fl;
        feat_ready  = fr;
        #1;
        mv = (qd.size() != 0);
        check("feat_valid", feat_valid, mv);
        if (mv) begin
            check("feat_data", feat_data, qd[0]);
            check("feat_ch", feat_ch, qc[0]);
        end
        rdy = rst_n && !fl && (qd.size() < DEP);
        check("coef_ready", coef_ready, rdy);
`ifdef MFCC_SAT_STATUS_EN
        check("sat_count", sat_count, 16'(satm));
`endif
        if (!rst_n || fl) begin
            for (int k = 0; k < NCH; k++) begin
                pos[k] = 0;
                for (int j = 0; j < F; j++) slot[k][j] = 0;
            end
            qd.delete();
            qc.delete();
            satm = 0;
        end else begin
            if (mv && fr) begin
                void'(qd.pop_front());
                void'(qc.pop_front());
            end
            if (v && rdy) model_accept(c, ch, n, sh);
        end
    endtask

    initial begin
        logic [FW-1:0] ev;
        int n, sh, c;
        model_clear();

        // Reset state
        #1 rst_n = 1'b0;
        cyc(0, 0, 0, 4, 0, 0, 0);
        check("rst_feat_data", feat_data, '0);
        check("rst_feat_ch", feat_ch, '0);
        cyc(0, 0, 0, 4, 0, 0, 0);
        rst_n = 1'b1;

        // Basic frame with saturation
        cyc(1, 1, 0, 4, 0, 0, 0);
        cyc(1, -2, 0, 4, 0, 0, 0);
        cyc(1, 127, 0, 4, 0, 0, 0);
        cyc(1, 300, 0, 4, 0, 0, 0);
        cyc(0, 0, 0, 4, 0, 0, 0);
        ev = '0;
        ev[7:0] = 8'h01; ev[15:8] = 8'hFE; ev[23:16] = 8'h7F; ev[31:24] = 8'h7F;
        check("tp1_valid", feat_valid, 1'b1);
        check("tp1_data", feat_data, ev);
`ifdef MFCC_SAT_STATUS_EN
        check("tp1_sat", sat_count, 16'd1);
`endif
        cyc(0, 0, 0, 4, 0, 0, 1);

        // Rounding shift, then a clipped negative
        cyc(1, 6, 0, 2, 2, 0, 1);
        cyc(1, -6, 0, 2, 2, 0, 1);
        cyc(0, 0, 0, 2, 2, 0, 0);
        ev = '0; ev[7:0] = 8'h02; ev[15:8] = 8'hFF;
        check("tp2_data", feat_data, ev);
        cyc(1, -600, 0, 2, 2, 0, 1);
        cyc(1, 0, 0, 2, 2, 0, 0);
        cyc(0, 0, 0, 2, 2, 0, 0);
        ev = '0; ev[7:0] = 8'h80;
        check("tp2_clip", feat_data, ev);
        cyc(0, 0, 0, 2, 2, 0, 1);

        // Backpressure: FIFO fills after two frames
        for (int i = 0; i < 6; i++) cyc(1, (i + 1) * 10, 0, 2, 0, 0, 0);
        check("tp3_full_ready", coef_ready, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1, i + 3, 0, 2, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 2, 0, 0, 1);

        // Interleaved channels
        for (int i = 0; i < 6; i++) cyc(1, (i + 1) * 7 - 20, i % 2, 3, 0, 0, 0);
        cyc(0, 0, 0, 3, 0, 0, 0);
        check("tp4_ch_first", feat_ch, 1'b0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 3, 0, 0, 1);

        // Flush mid-frame
        cyc(1, 50, 0, 4, 0, 0, 1);
        cyc(1, 51, 0, 4, 0, 0, 1);
        cyc(0, 0, 0, 4, 0, 1, 1);
        check("tp5_empty", feat_valid, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1, i - 2, 0, 4, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 4, 0, 0, 1);

        // Reset with one frame queued and a partial in flight
        cyc(1, 9, 0, 2, 0, 0, 0);
        cyc(1, 8, 0, 2, 0, 0, 0);
        cyc(1, 77, 0, 2, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("tp6_rst_valid", feat_valid, 1'b0);
        model_clear();
        cyc(0, 0, 0, 2, 0, 0, 0);
        rst_n = 1'b1;
        cyc(1, 4, 0, 2, 0, 0, 0);
        cyc(1, 5, 0, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 2, 0, 0, 1);

        // Randomised traffic
        n = 4; sh = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 5))
                    0: n = 0;  1: n = 2;  2: n = 3;
                    3: n = 5;  4: n = 40; default: n = 41;
                endcase
            end
            if ($urandom_range(0, 199) == 0) n = $urandom_range(1, 6);
            if (i % 16 == 0) sh = $urandom_range(0, 9);
            case ($urandom_range(0, 2))
                0:       c = $urandom_range(0, 400) - 200;
                1:       c = $urandom_range(0, 10000) - 5000;
                default: c = int'($urandom);
            endcase
            cyc($urandom_range(0, 3) != 0, c, $urandom_range(0, 1), n, sh,
                $urandom_range(0, 79) == 0, $urandom_range(0, 9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
